// File: rtl/cu_pkg.sv
// Shared types and encodings for the instruction sequencer and its decoder.
package cu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_W   = 3;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] d;
        logic [3:0] f;
        logic [2:0] h;
    } ctrl_word_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_SWAP = 4'hA,
        OP_CMP  = 4'hB,
        OP_CMOV = 4'hC,
        OP_RSVD = 4'hD,
        OP_ILL0 = 4'hE,
        OP_ILL1 = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_SW1  = 2'd1,
        S_SW2  = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MC_NONE = 2'd0,
        MC_SWAP = 2'd1,
        MC_CMOV = 2'd2
    } mc_e;

    localparam logic [3:0] F_PASSA = 4'd0;
    localparam logic [3:0] F_ADD   = 4'd1;
    localparam logic [3:0] F_SUB   = 4'd2;
    localparam logic [3:0] F_AND   = 4'd3;
    localparam logic [3:0] F_OR    = 4'd4;
    localparam logic [3:0] F_XOR   = 4'd5;

    localparam logic [2:0] H_NONE = 3'd0;
    localparam logic [2:0] H_SHL  = 3'd1;
    localparam logic [2:0] H_SHR  = 3'd2;

    // Register-to-register move: dst <- src through the ALU pass-through.
    function automatic ctrl_word_t mov_word(input logic [2:0] src, input logic [2:0] dst);
        ctrl_word_t w;
        w.a = src;
        w.b = 3'd0;
        w.d = dst;
        w.f = F_PASSA;
        w.h = H_NONE;
        return w;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational decode of op/rd/ra/rb into the first control word and sequencing kind.
module cu_decoder
    import cu_pkg::*;
#(
    parameter logic [2:0] TEMP_REG = 3'd7
) (
    input  logic [12:0] i_instr_hi,
    output ctrl_word_t  o_word,
    output logic        o_valid,
    output mc_e         o_kind,
    output logic        o_illegal
);

    op_e        w_op;
    logic [2:0] w_rd;
    logic [2:0] w_ra;
    logic [2:0] w_rb;

    assign w_op = op_e'(i_instr_hi[12:9]);
    assign w_rd = i_instr_hi[8:6];
    assign w_ra = i_instr_hi[5:3];
    assign w_rb = i_instr_hi[2:0];

    always_comb begin
        o_word    = '0;
        o_valid   = 1'b0;
        o_kind    = MC_NONE;
        o_illegal = 1'b0;
        case (w_op)
            OP_LOAD: begin o_word = mov_word(3'd0, w_rd); o_valid = 1'b1; end
            OP_MOV:  begin o_word = mov_word(w_ra, w_rd); o_valid = 1'b1; end
            OP_ADD:  begin o_word = '{w_ra, w_rb, w_rd, F_ADD, H_NONE}; o_valid = 1'b1; end
            OP_SUB:  begin o_word = '{w_ra, w_rb, w_rd, F_SUB, H_NONE}; o_valid = 1'b1; end
            OP_AND:  begin o_word = '{w_ra, w_rb, w_rd, F_AND, H_NONE}; o_valid = 1'b1; end
            OP_OR:   begin o_word = '{w_ra, w_rb, w_rd, F_OR,  H_NONE}; o_valid = 1'b1; end
            OP_XOR:  begin o_word = '{w_ra, w_rb, w_rd, F_XOR, H_NONE}; o_valid = 1'b1; end
            OP_SHL:  begin o_word = '{w_ra, 3'd0, w_rd, F_PASSA, H_SHL}; o_valid = 1'b1; end
            OP_SHR:  begin o_word = '{w_ra, 3'd0, w_rd, F_PASSA, H_SHR}; o_valid = 1'b1; end
            OP_CMP:  begin o_word = '{w_ra, w_rb, 3'd0, F_SUB, H_NONE}; o_valid = 1'b1; end
            OP_SWAP: begin
                o_word  = mov_word(w_ra, TEMP_REG);
                o_valid = 1'b1;
                o_kind  = MC_SWAP;
            end
            OP_CMOV: o_kind = MC_CMOV;
            OP_ILL0, OP_ILL1: o_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/unidad_control.sv
// Instruction sequencer: accepts instructions and expands them into datapath control words.
module unidad_control
    import cu_pkg::*;
#(
    parameter logic [2:0]  TEMP_REG = 3'd7,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic [15:0]      i_instr,
    input  logic [3:0]       i_flags_in,
    output logic [15:0]      o_ctrl_word,
    output logic             o_ctrl_valid,
    output logic             o_busy,
    output logic             o_illegal_op,
    output logic [CNT_W-1:0] o_retired
);

    state_e     r_state;
    ctrl_word_t r_word;
    logic       r_valid;
    logic       r_illegal;
    logic [CNT_W-1:0] r_retired;
    logic [2:0] r_rd;
    logic [2:0] r_ra;
    logic [2:0] r_cnd;

    ctrl_word_t w_dec_word;
    logic       w_dec_valid;
    mc_e        w_dec_kind;
    logic       w_dec_illegal;

    state_e     w_state_nxt;
    ctrl_word_t w_word_nxt;
    logic       w_valid_nxt;
    logic       w_retire;
    logic       w_illegal_nxt;
    logic [2:0] w_rd_nxt;
    logic [2:0] w_ra_nxt;
    logic [2:0] w_cnd_nxt;
    logic       w_cond;

    cu_decoder #(.TEMP_REG(TEMP_REG)) u_dec (
        .i_instr_hi (i_instr[15:3]),
        .o_word     (w_dec_word),
        .o_valid    (w_dec_valid),
        .o_kind     (w_dec_kind),
        .o_illegal  (w_dec_illegal)
    );

    // Condition for CMOV: selected flag, optionally inverted by cnd[2].
    assign w_cond = i_flags_in[r_cnd[1:0]] ^ r_cnd[2];

    always_comb begin
        w_state_nxt   = r_state;
        w_word_nxt    = '0;
        w_valid_nxt   = 1'b0;
        w_retire      = 1'b0;
        w_illegal_nxt = r_illegal;
        w_rd_nxt      = r_rd;
        w_ra_nxt      = r_ra;
        w_cnd_nxt     = r_cnd;
        case (r_state)
            S_RUN: begin
                if (i_instr_valid) begin
                    w_rd_nxt  = i_instr[11:9];
                    w_ra_nxt  = i_instr[8:6];
                    w_cnd_nxt = i_instr[2:0];
                    if (w_dec_illegal) begin
                        w_illegal_nxt = 1'b1;
                    end else begin
                        w_word_nxt  = w_dec_word;
                        w_valid_nxt = w_dec_valid;
                        case (w_dec_kind)
                            MC_SWAP: w_state_nxt = S_SW1;
                            MC_CMOV: w_state_nxt = S_WAIT;
                            default: w_retire    = 1'b1;
                        endcase
                    end
                end
            end
            S_SW1: begin
                w_word_nxt  = mov_word(r_rd, r_ra);
                w_valid_nxt = 1'b1;
                w_state_nxt = S_SW2;
            end
            S_SW2: begin
                w_word_nxt  = mov_word(TEMP_REG, r_rd);
                w_valid_nxt = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_WAIT: begin
                if (w_cond) begin
                    w_word_nxt  = mov_word(r_ra, r_rd);
                    w_valid_nxt = 1'b1;
                end
                w_retire    = 1'b1;
                w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_RUN;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= '0;
            r_rd      <= 3'd0;
            r_ra      <= 3'd0;
            r_cnd     <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_valid   <= w_valid_nxt;
            r_illegal <= w_illegal_nxt;
            r_rd      <= w_rd_nxt;
            r_ra      <= w_ra_nxt;
            r_cnd     <= w_cnd_nxt;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign o_instr_ready = (r_state == S_RUN);
    assign o_busy        = (r_state != S_RUN);
    assign o_ctrl_word   = r_word;
    assign o_ctrl_valid  = r_valid;
    assign o_illegal_op  = r_illegal;
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_unidad_control.sv
// Directed bench for unidad_control with hand-computed control words.
module tb_unidad_control;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  flags_in;
    logic [15:0] ctrl_word;
    logic        ctrl_valid;
    logic        busy;
    logic        illegal_op;
    logic [7:0]  retired;

    int n_vec = 0;
    int n_err = 0;

    unidad_control dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_instr_valid (instr_valid),
        .o_instr_ready (instr_ready),
        .i_instr       (instr),
        .i_flags_in    (flags_in),
        .o_ctrl_word   (ctrl_word),
        .o_ctrl_valid  (ctrl_valid),
        .o_busy        (busy),
        .o_illegal_op  (illegal_op),
        .o_retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        flags_in    = 4'h0;
        #12;
        chk("rst_word",    ctrl_word, 16'h0000);
        chk("rst_valid",   16'(ctrl_valid), 16'h0);
        chk("rst_illegal", 16'(illegal_op), 16'h0);
        chk("rst_retired", 16'(retired), 16'h0);
        chk("rst_ready",   16'(instr_ready), 16'h1);
        chk("rst_busy",    16'(busy), 16'h0);
        #10;
        rst_n = 1'b1;

        // ADD r3 = r1 + r2
        instr_valid = 1'b1; instr = 16'h3650;
        tick();
        instr_valid = 1'b0;
        chk("add_word",    ctrl_word, 16'h2988);
        chk("add_valid",   16'(ctrl_valid), 16'h1);
        chk("add_retired", 16'(retired), 16'd1);

        // LOAD r5 then MOV r2 <- r5 back to back
        instr_valid = 1'b1; instr = 16'h1A00;
        tick();
        chk("load_word",  ctrl_word, 16'h0280);
        chk("load_ready", 16'(instr_ready), 16'h1);
        instr = 16'h2540;
        tick();
        instr_valid = 1'b0;
        chk("mov_word",    ctrl_word, 16'hA100);
        chk("mov_ready",   16'(instr_ready), 16'h1);
        chk("mov_retired", 16'(retired), 16'd3);
        tick();
        chk("idle_word",  ctrl_word, 16'h0000);
        chk("idle_valid", 16'(ctrl_valid), 16'h0);

        // SWAP r1 <-> r2
        instr_valid = 1'b1; instr = 16'hA280;
        tick();
        instr_valid = 1'b0;
        chk("sw1_word",    ctrl_word, 16'h4380);
        chk("sw1_ready",   16'(instr_ready), 16'h0);
        chk("sw1_busy",    16'(busy), 16'h1);
        chk("sw1_retired", 16'(retired), 16'd3);
        tick();
        chk("sw2_word",    ctrl_word, 16'h2100);
        chk("sw2_ready",   16'(instr_ready), 16'h0);
        chk("sw2_retired", 16'(retired), 16'd3);
        tick();
        chk("sw3_word",    ctrl_word, 16'hE080);
        chk("sw3_valid",   16'(ctrl_valid), 16'h1);
        chk("sw3_ready",   16'(instr_ready), 16'h1);
        chk("sw3_retired", 16'(retired), 16'd4);

        // CMP r1,r2 then CMOV r4 <- r6 on Z, Z=1
        instr_valid = 1'b1; instr = 16'hB050;
        tick();
        chk("cmp_word",    ctrl_word, 16'h2810);
        chk("cmp_retired", 16'(retired), 16'd5);
        instr = 16'hC980;
        tick();
        instr_valid = 1'b0;
        flags_in = 4'b0001;
        chk("cmovt_wait_word",  ctrl_word, 16'h0000);
        chk("cmovt_wait_valid", 16'(ctrl_valid), 16'h0);
        chk("cmovt_wait_ready", 16'(instr_ready), 16'h0);
        tick();
        chk("cmovt_word",    ctrl_word, 16'hC200);
        chk("cmovt_valid",   16'(ctrl_valid), 16'h1);
        chk("cmovt_retired", 16'(retired), 16'd6);
        chk("cmovt_ready",   16'(instr_ready), 16'h1);

        // Same with Z=0: condition false
        instr_valid = 1'b1; instr = 16'hB050;
        tick();
        instr = 16'hC980;
        tick();
        instr_valid = 1'b0;
        flags_in = 4'b1110;
        chk("cmovf_wait_valid", 16'(ctrl_valid), 16'h0);
        tick();
        chk("cmovf_word",    ctrl_word, 16'h0000);
        chk("cmovf_valid",   16'(ctrl_valid), 16'h0);
        chk("cmovf_retired", 16'(retired), 16'd8);

        // Inverted condition (cnd=4, not Z) with Z=0 moves
        instr_valid = 1'b1; instr = 16'hC984;
        tick();
        instr_valid = 1'b0;
        flags_in = 4'b0000;
        tick();
        chk("cmovi_word",    ctrl_word, 16'hC200);
        chk("cmovi_retired", 16'(retired), 16'd9);

        // SHL r3 <- r4
        instr_valid = 1'b1; instr = 16'h8700;
        tick();
        chk("shl_word", ctrl_word, 16'h8181);

        // Illegal op, then a legal op keeps the sticky flag
        instr = 16'hF000;
        tick();
        chk("ill_word",    ctrl_word, 16'h0000);
        chk("ill_valid",   16'(ctrl_valid), 16'h0);
        chk("ill_flag",    16'(illegal_op), 16'h1);
        chk("ill_retired", 16'(retired), 16'd10);
        instr = 16'h3650;
        tick();
        chk("ill_sticky",  16'(illegal_op), 16'h1);
        chk("post_ill_retired", 16'(retired), 16'd11);

        // NOPs to 255, then one more wraps to 0
        instr = 16'h0000;
        for (int i = 0; i < 244; i++) tick();
        chk("nop_valid",   16'(ctrl_valid), 16'h0);
        chk("cnt_255",     16'(retired), 16'd255);
        tick();
        chk("cnt_wrap",    16'(retired), 16'd0);
        instr_valid = 1'b0;

        // Reset while in S_SW1
        instr_valid = 1'b1; instr = 16'hA280;
        tick();
        instr_valid = 1'b0;
        chk("mid_busy", 16'(busy), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_word",    ctrl_word, 16'h0000);
        chk("mid_rst_valid",   16'(ctrl_valid), 16'h0);
        chk("mid_rst_busy",    16'(busy), 16'h0);
        chk("mid_rst_retired", 16'(retired), 16'h0);
        chk("mid_rst_illegal", 16'(illegal_op), 16'h0);
        #2;
        rst_n = 1'b1;
        chk("mid_rel_ready", 16'(instr_ready), 16'h1);
        tick();
        chk("mid_after_word",  ctrl_word, 16'h0000);
        chk("mid_after_valid", 16'(ctrl_valid), 16'h0);
        tick();
        chk("mid_after2_word",  ctrl_word, 16'h0000);
        chk("mid_after2_retired", 16'(retired), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
